// File: rtl/shift_sequencer.sv
// Multi-cycle shifter for the KGP-RISC shift class: one bit per clock, start/busy/done handshake,
// result plus carry/zero/sign/illegal flags held until the next accepted start.
module shift_sequencer #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       funcCode,
  input  logic [WIDTH-1:0] operand,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             sign,
  output logic             illegal
);

  // Handshake: a request is taken when start=1 and busy=0 at a rising edge; the
  // result and flags are valid in the single cycle where done=1 and hold afterwards.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] sr, sr_shift;
  logic [SHW-1:0]   count;
  logic             dir_left, is_log;
  logic             carry_q, zero_q, sign_q, illegal_q;
  logic             bit_out, fill;
  logic             accept, dec_illegal, dec_left, dec_log, last_shift;

  assign accept     = start && (state == IDLE);
  assign last_shift = (state == SHIFT) && (count == SHW'(1));

  always_comb begin
    dec_illegal = 1'b0;
    dec_left    = 1'b0;
    dec_log     = 1'b1;
    unique case (funcCode)
      5'b00011, 5'b00100: dec_left = 1'b1;
      5'b00101:           dec_left = 1'b0;
      5'b00110:           dec_log  = 1'b0;
      default:            dec_illegal = 1'b1;
    endcase
  end

  // One-bit step of the shift register in the latched mode.
  always_comb begin
    fill = is_log ? 1'b0 : sr[WIDTH-1];
    if (dir_left) begin
      sr_shift = {sr[WIDTH-2:0], 1'b0};
      bit_out  = sr[WIDTH-1];
    end else begin
      sr_shift = {fill, sr[WIDTH-1:1]};
      bit_out  = sr[0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (dec_illegal || (shamt == '0)) state_next = DONE;
          else                              state_next = SHIFT;
        end
      end
      SHIFT:   if (count == SHW'(1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sr        <= '0;
      count     <= '0;
      dir_left  <= 1'b0;
      is_log    <= 1'b1;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      sign_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else if (accept) begin
      sr        <= operand;
      count     <= shamt;
      dir_left  <= dec_left;
      is_log    <= dec_log;
      carry_q   <= 1'b0;
      illegal_q <= dec_illegal;
      // Zero-length and illegal requests complete next cycle, so their flags settle now.
      if (dec_illegal || (shamt == '0)) begin
        zero_q <= (operand == '0);
        sign_q <= operand[WIDTH-1];
      end else begin
        zero_q <= 1'b0;
        sign_q <= 1'b0;
      end
    end else if (state == SHIFT) begin
      sr      <= sr_shift;
      carry_q <= bit_out;
      count   <= count - SHW'(1);
      if (last_shift) begin
        zero_q <= (sr_shift == '0);
        sign_q <= sr_shift[WIDTH-1];
      end
    end
  end

  assign result  = sr;
  assign carry   = carry_q;
  assign zero    = zero_q;
  assign sign    = sign_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: hand-computed results, flags, latency and busy length.
module tb_shift_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [4:0]  funcCode;
  logic [31:0] operand;
  logic [4:0]  shamt;
  logic        busy, done, carry, zero, sign, illegal;
  logic [31:0] result;

  int n_cmp = 0;
  int n_bad = 0;

  shift_sequencer #(.WIDTH(32), .SHW(5)) dut (
    .clk(clk), .reset(reset), .start(start), .funcCode(funcCode),
    .operand(operand), .shamt(shamt), .busy(busy), .done(done),
    .result(result), .carry(carry), .zero(zero), .sign(sign), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one op, then watch negedges until done. Start is re-pulsed at
  // cycle offsets poke_a/poke_b with a different request that must be ignored.
  task automatic run_op(input logic [4:0] fc, input logic [31:0] op, input logic [4:0] sh,
                        input int poke_a, input int poke_b, output int lat, output int busy_n);
    @(negedge clk);
    funcCode = fc; operand = op; shamt = sh; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; funcCode = 5'b00101; operand = 32'h5555_AAAA; shamt = 5'd2;
    lat = 0;
    busy_n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) begin
        lat = i;
        break;
      end
      start = (i == poke_a) || (i == poke_b);
    end
    start = 1'b0;
    if (lat == 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_flags(input string tag, input logic [31:0] r, input logic c,
                           input logic z, input logic s, input logic il);
    chk({tag, "_result"}, result, r);
    chk({tag, "_carry"}, {31'd0, carry}, {31'd0, c});
    chk({tag, "_zero"}, {31'd0, zero}, {31'd0, z});
    chk({tag, "_sign"}, {31'd0, sign}, {31'd0, s});
    chk({tag, "_illegal"}, {31'd0, illegal}, {31'd0, il});
  endtask

  int lat, bn, seen, first_at, second_at;

  initial begin
    reset = 1'b0; start = 1'b0; funcCode = '0; operand = '0; shamt = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk_flags("rst", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;

    // 1: abort an in-flight shll 0xFF by 10 with a 2-cycle reset
    @(negedge clk);
    funcCode = 5'b00011; operand = 32'h0000_00FF; shamt = 5'd10; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk_flags("abort", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("abort_no_done", seen, 32'd0);

    // 2: left logical 0x8000_0001 by 1
    run_op(5'b00100, 32'h8000_0001, 5'd1, -1, -1, lat, bn);
    chk("sll1_lat", lat, 32'd2);
    chk("sll1_busy", bn, 32'd2);
    chk_flags("sll1", 32'h0000_0002, 1'b1, 1'b0, 1'b0, 1'b0);

    // 3: arithmetic right 0x8000_0000 by 31 with ignored start pulses
    run_op(5'b00110, 32'h8000_0000, 5'd31, 5, 20, lat, bn);
    chk("sra31_lat", lat, 32'd32);
    chk("sra31_busy", bn, 32'd32);
    chk_flags("sra31", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("sra31_idle_after", {31'd0, busy}, 32'd0);
    chk("sra31_hold", result, 32'hFFFF_FFFF);

    // 4: right logical 1 by 1, then shamt=0 passthrough
    run_op(5'b00101, 32'h0000_0001, 5'd1, -1, -1, lat, bn);
    chk("srl1_lat", lat, 32'd2);
    chk_flags("srl1", 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    run_op(5'b00101, 32'h1234_5678, 5'd0, -1, -1, lat, bn);
    chk("srl0_lat", lat, 32'd1);
    chk("srl0_busy", bn, 32'd1);
    chk_flags("srl0", 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0);

    // 5: illegal code, then a legal op clears illegal
    run_op(5'b00000, 32'hDEAD_BEEF, 5'd4, -1, -1, lat, bn);
    chk("ill_lat", lat, 32'd1);
    chk_flags("ill", 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 1'b1);
    run_op(5'b00011, 32'h0000_00F0, 5'd4, -1, -1, lat, bn);
    chk("after_ill_lat", lat, 32'd5);
    chk_flags("after_ill", 32'h0000_0F00, 1'b0, 1'b0, 1'b0, 1'b0);

    // shll by the maximum amount; the last bit out is a 1
    run_op(5'b00011, 32'h0000_0003, 5'd31, -1, -1, lat, bn);
    chk("sll31_lat", lat, 32'd32);
    chk_flags("sll31", 32'h8000_0000, 1'b1, 1'b0, 1'b1, 1'b0);

    // 6: back-to-back with start held high
    @(negedge clk);
    funcCode = 5'b00011; operand = 32'h0000_0001; shamt = 5'd3; start = 1'b1;
    @(posedge clk);
    #1;
    first_at = 0;
    second_at = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done && first_at == 0) begin
        first_at = i;
        chk("b2b_first_result", result, 32'h0000_0008);
        funcCode = 5'b00101; operand = 32'h0000_0077; shamt = 5'd0;
      end else if (done) begin
        second_at = i;
        break;
      end
    end
    start = 1'b0;
    chk("b2b_first_lat", first_at, 32'd4);
    chk("b2b_second_lat", second_at, 32'd6);
    chk("b2b_second_result", result, 32'h0000_0077);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
